// File: rtl/nav_event_arbiter.sv
// Merges button and FFT navigation pulses into one ordered event stream:
// per-source pending registers, round-robin grant into a small FIFO, and an FFT holdoff window.
module nav_event_arbiter #(
   parameter int HOLDOFF_CYCLES = 5_000_000,
   parameter int CNT_W          = 23,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       btn_up_in,
   input  logic       btn_down_in,
   input  logic       btn_sel_in,
   input  logic       fft_hi_in,
   input  logic       fft_lo_in,
   input  logic       fft_en_in,
   input  logic       evt_ready_in,
   output logic       evt_valid_out,
   output logic [1:0] evt_code_out,
   output logic       evt_src_out,
   output logic       holdoff_active_out,
   output logic [7:0] drop_count_out,
   output logic [2:0] fifo_count_out
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

   logic             btn_pend_valid_reg, btn_pend_valid_next;
   logic [1:0]       btn_pend_code_reg, btn_pend_code_next;
   logic             fft_pend_valid_reg, fft_pend_valid_next;
   logic [1:0]       fft_pend_code_reg, fft_pend_code_next;
   logic [CNT_W-1:0] holdoff_cnt_reg, holdoff_cnt_next;
   logic [7:0]       drop_count_reg, drop_count_next;
   logic             rr_fft_reg, rr_fft_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [2:0]       fifo_count_reg, fifo_count_next;
   logic [2:0]       fifo_mem [FIFO_DEPTH];

   logic       btn_cand_valid, fft_cand_valid;
   logic [1:0] btn_cand_code, fft_cand_code;
   logic       can_push, fft_pend_live, grant_btn, grant_fft;
   logic       btn_load, fft_load, btn_drop, fft_drop;
   logic       push, pop;
   logic [2:0] push_data, head_data;
   logic [8:0] drop_sum;

   always_comb begin
      btn_cand_valid = btn_sel_in | (btn_up_in ^ btn_down_in);
      btn_cand_code  = btn_sel_in ? 2'd3 : (btn_up_in ? 2'd1 : 2'd2);
      // Holdoff and disable suppress FFT pulses outright; they never count as drops.
      fft_cand_valid = fft_en_in & (holdoff_cnt_reg == '0) & (fft_hi_in ^ fft_lo_in);
      fft_cand_code  = fft_hi_in ? 2'd1 : 2'd2;

      can_push      = fifo_count_reg < DEPTH_C;
      fft_pend_live = fft_pend_valid_reg & fft_en_in;
      grant_btn     = can_push & btn_pend_valid_reg & (~fft_pend_live | ~rr_fft_reg);
      grant_fft     = can_push & fft_pend_live & (~btn_pend_valid_reg | rr_fft_reg);

      btn_load = btn_cand_valid & (~btn_pend_valid_reg | grant_btn);
      fft_load = fft_cand_valid & (~fft_pend_valid_reg | grant_fft);
      btn_drop = btn_cand_valid & ~btn_load;
      fft_drop = fft_cand_valid & ~fft_load;

      btn_pend_valid_next = btn_load | (btn_pend_valid_reg & ~grant_btn);
      btn_pend_code_next  = btn_load ? btn_cand_code : btn_pend_code_reg;
      fft_pend_valid_next = fft_en_in & (fft_load | (fft_pend_valid_reg & ~grant_fft));
      fft_pend_code_next  = fft_load ? fft_cand_code : fft_pend_code_reg;

      holdoff_cnt_next = holdoff_cnt_reg;
      if (!fft_en_in)
         holdoff_cnt_next = '0;
      else if (fft_load)
         holdoff_cnt_next = HOLD_LOAD;
      else if (holdoff_cnt_reg != '0)
         holdoff_cnt_next = holdoff_cnt_reg - 1'b1;

      drop_sum        = {1'b0, drop_count_reg} + 9'(btn_drop) + 9'(fft_drop);
      drop_count_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

      rr_fft_next = rr_fft_reg;
      if (grant_btn)
         rr_fft_next = 1'b1;
      else if (grant_fft)
         rr_fft_next = 1'b0;

      push      = grant_btn | grant_fft;
      push_data = grant_fft ? {1'b1, fft_pend_code_reg} : {1'b0, btn_pend_code_reg};
      pop       = (fifo_count_reg != 3'd0) & evt_ready_in;

      wr_ptr_next     = wr_ptr_reg + PTR_W'(push);
      rd_ptr_next     = rd_ptr_reg + PTR_W'(pop);
      fifo_count_next = fifo_count_reg;
      if (push && !pop)
         fifo_count_next = fifo_count_reg + 3'd1;
      else if (!push && pop)
         fifo_count_next = fifo_count_reg - 3'd1;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         btn_pend_valid_reg <= 1'b0;
         btn_pend_code_reg  <= 2'd0;
         fft_pend_valid_reg <= 1'b0;
         fft_pend_code_reg  <= 2'd0;
         holdoff_cnt_reg    <= '0;
         drop_count_reg     <= 8'd0;
         rr_fft_reg         <= 1'b0;
         wr_ptr_reg         <= '0;
         rd_ptr_reg         <= '0;
         fifo_count_reg     <= 3'd0;
      end else begin
         btn_pend_valid_reg <= btn_pend_valid_next;
         btn_pend_code_reg  <= btn_pend_code_next;
         fft_pend_valid_reg <= fft_pend_valid_next;
         fft_pend_code_reg  <= fft_pend_code_next;
         holdoff_cnt_reg    <= holdoff_cnt_next;
         drop_count_reg     <= drop_count_next;
         rr_fft_reg         <= rr_fft_next;
         wr_ptr_reg         <= wr_ptr_next;
         rd_ptr_reg         <= rd_ptr_next;
         fifo_count_reg     <= fifo_count_next;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk_in) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= push_data;
   end

   assign head_data          = fifo_mem[rd_ptr_reg];
   assign evt_valid_out      = fifo_count_reg != 3'd0;
   assign evt_code_out       = evt_valid_out ? head_data[1:0] : 2'd0;
   assign evt_src_out        = evt_valid_out ? head_data[2] : 1'b0;
   assign holdoff_active_out = holdoff_cnt_reg != '0;
   assign drop_count_out     = drop_count_reg;
   assign fifo_count_out     = fifo_count_reg;

endmodule

// File: tb/tb_nav_event_arbiter.sv
// Directed self-checking bench for nav_event_arbiter, built with an 8-cycle FFT holdoff.
module tb_nav_event_arbiter;

   logic       clk_in = 1'b0;
   logic       rst_n_in;
   logic       btn_up_in, btn_down_in, btn_sel_in;
   logic       fft_hi_in, fft_lo_in, fft_en_in;
   logic       evt_ready_in;
   logic       evt_valid_out;
   logic [1:0] evt_code_out;
   logic       evt_src_out;
   logic       holdoff_active_out;
   logic [7:0] drop_count_out;
   logic [2:0] fifo_count_out;

   int errors = 0;
   int checks = 0;

   nav_event_arbiter #(
      .HOLDOFF_CYCLES(8),
      .CNT_W(4),
      .FIFO_DEPTH(4)
   ) dut (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .btn_up_in(btn_up_in),
      .btn_down_in(btn_down_in),
      .btn_sel_in(btn_sel_in),
      .fft_hi_in(fft_hi_in),
      .fft_lo_in(fft_lo_in),
      .fft_en_in(fft_en_in),
      .evt_ready_in(evt_ready_in),
      .evt_valid_out(evt_valid_out),
      .evt_code_out(evt_code_out),
      .evt_src_out(evt_src_out),
      .holdoff_active_out(holdoff_active_out),
      .drop_count_out(drop_count_out),
      .fifo_count_out(fifo_count_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clear_pulses();
      btn_up_in = 1'b0; btn_down_in = 1'b0; btn_sel_in = 1'b0;
      fft_hi_in = 1'b0; fft_lo_in = 1'b0;
   endtask

   task automatic do_reset();
      clear_pulses();
      fft_en_in    = 1'b1;
      evt_ready_in = 1'b0;
      rst_n_in     = 1'b0;
      tick();
      tick();
      rst_n_in = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (evt_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", evt_valid_out); end
      checks++; if (evt_code_out !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", evt_code_out); end
      checks++; if (evt_src_out !== 1'b0) begin errors++; $display("FAIL reset_src: got %0b expected 0", evt_src_out); end
      checks++; if (holdoff_active_out !== 1'b0) begin errors++; $display("FAIL reset_holdoff: got %0b expected 0", holdoff_active_out); end
      checks++; if (drop_count_out !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count_out); end
      checks++; if (fifo_count_out !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count_out); end
   endtask

   task automatic test_single();
      tick(); tick();
      btn_up_in = 1'b1;
      tick();
      btn_up_in = 1'b0;
      checks++; if (evt_valid_out !== 1'b0) begin errors++; $display("FAIL single_latency1: got valid=%0b expected 0", evt_valid_out); end
      tick();
      checks++; if (evt_valid_out !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", evt_valid_out); end
      checks++; if (evt_code_out !== 2'd1 || evt_src_out !== 1'b0) begin errors++; $display("FAIL single_head: got code=%0d src=%0b expected code=1 src=0", evt_code_out, evt_src_out); end
      $display("single: pop code=%0d src=%0b", evt_code_out, evt_src_out);
      evt_ready_in = 1'b1;
      tick();
      evt_ready_in = 1'b0;
      checks++; if (evt_valid_out !== 1'b0 || evt_code_out !== 2'd0 || fifo_count_out !== 3'd0) begin errors++; $display("FAIL single_pop: got valid=%0b code=%0d count=%0d expected 0 0 0", evt_valid_out, evt_code_out, fifo_count_out); end
   endtask

   task automatic test_both_sources();
      do_reset();
      btn_up_in = 1'b1; fft_lo_in = 1'b1;
      tick();
      clear_pulses();
      tick();
      checks++; if (fifo_count_out !== 3'd1 || evt_code_out !== 2'd1 || evt_src_out !== 1'b0) begin errors++; $display("FAIL both_first: got count=%0d code=%0d src=%0b expected 1 1 0", fifo_count_out, evt_code_out, evt_src_out); end
      tick();
      checks++; if (fifo_count_out !== 3'd2) begin errors++; $display("FAIL both_count: got %0d expected 2", fifo_count_out); end
      checks++; if (holdoff_active_out !== 1'b1) begin errors++; $display("FAIL both_holdoff: got %0b expected 1", holdoff_active_out); end
      evt_ready_in = 1'b1;
      tick();
      checks++; if (evt_code_out !== 2'd2 || evt_src_out !== 1'b1 || fifo_count_out !== 3'd1) begin errors++; $display("FAIL both_second: got code=%0d src=%0b count=%0d expected 2 1 1", evt_code_out, evt_src_out, fifo_count_out); end
      $display("both: pop code=%0d src=%0b", evt_code_out, evt_src_out);
      tick();
      evt_ready_in = 1'b0;
      checks++; if (evt_valid_out !== 1'b0) begin errors++; $display("FAIL both_empty: got valid=%0b expected 0", evt_valid_out); end
   endtask

   task automatic test_holdoff();
      logic exp_hold;
      do_reset();
      for (int c = 0; c <= 12; c++) begin
         fft_hi_in = (c == 0 || c == 3 || c == 9);
         tick();
         fft_hi_in = 1'b0;
         exp_hold = (c <= 6) || (c >= 9);
         checks++; if (holdoff_active_out !== exp_hold) begin errors++; $display("FAIL holdoff_active_c%0d: got %0b expected %0b", c, holdoff_active_out, exp_hold); end
      end
      checks++; if (fifo_count_out !== 3'd2) begin errors++; $display("FAIL holdoff_count: got %0d expected 2", fifo_count_out); end
      checks++; if (drop_count_out !== 8'd0) begin errors++; $display("FAIL holdoff_drop: got %0d expected 0", drop_count_out); end
      evt_ready_in = 1'b1;
      for (int k = 0; k < 2; k++) begin
         checks++; if (evt_valid_out !== 1'b1 || evt_code_out !== 2'd1 || evt_src_out !== 1'b1) begin errors++; $display("FAIL holdoff_evt%0d: got valid=%0b code=%0d src=%0b expected 1 1 1", k, evt_valid_out, evt_code_out, evt_src_out); end
         $display("holdoff: pop code=%0d src=%0b", evt_code_out, evt_src_out);
         tick();
      end
      evt_ready_in = 1'b0;
      checks++; if (fifo_count_out !== 3'd0) begin errors++; $display("FAIL holdoff_drained: got %0d expected 0", fifo_count_out); end
   endtask

   task automatic pulse_btn(input int code);
      btn_up_in   = (code == 1);
      btn_down_in = (code == 2);
      btn_sel_in  = (code == 3);
      tick();
      clear_pulses();
      tick();
      tick();
   endtask

   task automatic test_fifo_full();
      int codes [6] = '{1, 2, 1, 2, 3, 1};
      int n;
      do_reset();
      for (int i = 0; i < 6; i++) pulse_btn(codes[i]);
      checks++; if (fifo_count_out !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", fifo_count_out); end
      checks++; if (drop_count_out !== 8'd1) begin errors++; $display("FAIL full_drop: got %0d expected 1", drop_count_out); end
      evt_ready_in = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (evt_valid_out) begin
            $display("full: pop code=%0d src=%0b", evt_code_out, evt_src_out);
            checks++;
            if (n >= 5 || evt_code_out !== 2'(codes[n]) || evt_src_out !== 1'b0) begin
               errors++;
               $display("FAIL full_order%0d: got code=%0d src=%0b expected code=%0d src=0", n, evt_code_out, evt_src_out, (n < 5) ? codes[n] : 0);
            end
            n++;
         end
         tick();
      end
      evt_ready_in = 1'b0;
      checks++; if (n != 5) begin errors++; $display("FAIL full_drain_count: got %0d events expected 5", n); end
      checks++; if (fifo_count_out !== 3'd0 || drop_count_out !== 8'd1) begin errors++; $display("FAIL full_final: got count=%0d drop=%0d expected 0 1", fifo_count_out, drop_count_out); end
   endtask

   task automatic test_cancel();
      do_reset();
      btn_up_in = 1'b1; btn_down_in = 1'b1;
      tick();
      clear_pulses();
      tick(); tick(); tick();
      checks++; if (evt_valid_out !== 1'b0 || fifo_count_out !== 3'd0 || drop_count_out !== 8'd0) begin errors++; $display("FAIL cancel_updown: got valid=%0b count=%0d drop=%0d expected 0 0 0", evt_valid_out, fifo_count_out, drop_count_out); end
      btn_sel_in = 1'b1; btn_up_in = 1'b1;
      tick();
      clear_pulses();
      tick();
      checks++; if (evt_valid_out !== 1'b1 || evt_code_out !== 2'd3 || evt_src_out !== 1'b0) begin errors++; $display("FAIL cancel_sel: got valid=%0b code=%0d src=%0b expected 1 3 0", evt_valid_out, evt_code_out, evt_src_out); end
      tick(); tick();
      checks++; if (fifo_count_out !== 3'd1 || drop_count_out !== 8'd0) begin errors++; $display("FAIL cancel_single: got count=%0d drop=%0d expected 1 0", fifo_count_out, drop_count_out); end
   endtask

   task automatic test_en_reset();
      int seen;
      do_reset();
      pulse_btn(1);
      pulse_btn(2);
      checks++; if (fifo_count_out !== 3'd2) begin errors++; $display("FAIL enrst_queued: got %0d expected 2", fifo_count_out); end
      fft_lo_in = 1'b1;
      tick();
      fft_lo_in = 1'b0;
      fft_en_in = 1'b0;
      tick();
      checks++; if (holdoff_active_out !== 1'b0) begin errors++; $display("FAIL enrst_holdoff_clear: got %0b expected 0", holdoff_active_out); end
      rst_n_in = 1'b0;
      tick();
      checks++; if (evt_valid_out !== 1'b0 || evt_code_out !== 2'd0 || evt_src_out !== 1'b0 || holdoff_active_out !== 1'b0 || drop_count_out !== 8'd0 || fifo_count_out !== 3'd0) begin
         errors++;
         $display("FAIL enrst_outputs: got valid=%0b code=%0d src=%0b hold=%0b drop=%0d count=%0d expected all 0", evt_valid_out, evt_code_out, evt_src_out, holdoff_active_out, drop_count_out, fifo_count_out);
      end
      rst_n_in = 1'b1;
      fft_en_in = 1'b1;
      evt_ready_in = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (evt_valid_out) seen++;
      end
      evt_ready_in = 1'b0;
      checks++; if (seen != 0) begin errors++; $display("FAIL enrst_no_events: got %0d valid cycles expected 0", seen); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_both_sources();
      test_holdoff();
      test_fifo_full();
      test_cancel();
      test_en_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
